// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with programmable wait states
module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic        byte_q, byte_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [2**ADDR_W];

  logic [ADDR_W-1:0] widx;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic              req_err;
  logic              access;

  assign widx    = addr_q[ADDR_W+1:2];
  assign rd_word = mem_q[widx];
  assign rd_byte = rd_word[{addr_q[1:0], 3'b000} +: 8];
  // Out-of-range upper address bits, or a misaligned word access
  assign req_err = ((addr_q >> (ADDR_W + 2)) != 32'd0) | (~byte_q & (addr_q[1:0] != 2'b00));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    byte_d  = byte_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    access  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          byte_d  = req_byte;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access  = 1'b1;
          state_d = S_RESP;
          err_d   = req_err;
          if (req_err) begin
            rdata_d = 32'd0;
          end else if (!we_q) begin
            rdata_d = byte_q ? {24'd0, rd_byte} : rd_word;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      byte_q  <= byte_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM is not reset; byte stores touch only their own lane
  always_ff @(posedge clk) begin
    if (access && we_q && !req_err) begin
      if (byte_q) begin
        mem_q[widx][{addr_q[1:0], 3'b000} +: 8] <= wdata_q[7:0];
      end else begin
        mem_q[widx] <= wdata_q;
      end
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign stall     = (state_q == S_WAIT) | ((state_q == S_IDLE) & req_valid);

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed table-driven bench for dmem_responder
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_byte = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, stall;
  logic [31:0] rsp_rdata;

  logic        req_valid_b = 1'b0, req_we_b = 1'b0, req_byte_b = 1'b0;
  logic [31:0] req_addr_b = '0, req_wdata_b = '0;
  logic        req_ready_b, rsp_valid_b, rsp_err_b, stall_b;
  logic [31:0] rsp_rdata_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we), .req_byte(req_byte),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .stall(stall)
  );

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_we(req_we_b), .req_byte(req_byte_b),
    .req_addr(req_addr_b), .req_wdata(req_wdata_b), .req_ready(req_ready_b), .rsp_valid(rsp_valid_b),
    .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b), .stall(stall_b)
  );

  typedef struct {
    logic        we;
    logic        bt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    bit          chk_rdata;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic we, input logic bt,
                       input logic [31:0] a, input logic [31:0] wd);
    if (sel) begin
      req_valid_b = v; req_we_b = we; req_byte_b = bt; req_addr_b = a; req_wdata_b = wd;
    end else begin
      req_valid = v; req_we = we; req_byte = bt; req_addr = a; req_wdata = wd;
    end
  endtask

  task automatic txn(input bit sel, input vec_t v, input string nm);
    int n;
    bit got, stall_ok;
    int exp_lat;
    exp_lat = sel ? 1 : 3;
    @(negedge clk);
    drive(sel, 1'b1, v.we, v.bt, v.addr, v.wdata);
    #1;
    chk({nm, " stall_req"}, {31'd0, sel ? stall_b : stall}, 32'd1);
    chk({nm, " ready_idle"}, {31'd0, sel ? req_ready_b : req_ready}, 32'd1);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    n = 0; got = 0; stall_ok = 1;
    while (n < 20 && !got) begin
      if (sel ? rsp_valid_b : rsp_valid) got = 1;
      else begin
        if (!(sel ? stall_b : stall)) stall_ok = 0;
        @(posedge clk);
        #2;
        n++;
      end
    end
    chk({nm, " latency"}, n, exp_lat);
    chk({nm, " stall_wait"}, {31'd0, stall_ok}, 32'd1);
    chk({nm, " stall_resp"}, {31'd0, sel ? stall_b : stall}, 32'd0);
    chk({nm, " err"}, {31'd0, sel ? rsp_err_b : rsp_err}, {31'd0, v.exp_err});
    if (v.chk_rdata) chk({nm, " rdata"}, sel ? rsp_rdata_b : rsp_rdata, v.exp_rdata);
    @(posedge clk);
    #1;
    chk({nm, " one_cycle"}, {31'd0, sel ? rsp_valid_b : rsp_valid}, 32'd0);
    chk({nm, " ready_back"}, {31'd0, sel ? req_ready_b : req_ready}, 32'd1);
  endtask

  vec_t tbl [14];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 32'h40,   32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 32'h40,   32'h0,        32'hDEADBEEF, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 32'h80,   32'h11223344, 32'h0,        1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 32'h82,   32'hFFFFFFAA, 32'h0,        1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 32'h80,   32'h0,        32'h11AA3344, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 32'h83,   32'h0,        32'h00000011, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 32'h82,   32'h0,        32'h000000AA, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 32'h81,   32'h0,        32'h0,        1'b1, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 32'h100,  32'hCAFEF00D, 32'h0,        1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 32'h101,  32'h12345678, 32'h0,        1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 32'h100,  32'h0,        32'hCAFEF00D, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 32'h1000, 32'h0,        32'h0,        1'b1, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 32'h40,   32'h0,        32'hDEADBEEF, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 32'h20,   32'h0,        32'h0,        1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst ready", {31'd0, req_ready}, 32'd1);
    chk("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst rdata", rsp_rdata, 32'd0);
    chk("rst err", {31'd0, rsp_err}, 32'd0);
    chk("rst stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) txn(1'b0, tbl[i], $sformatf("vec%0d", i));

    // Back-to-back with req_valid held high; fields change right after each accept
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h80, 32'h0);
    begin
      int lows;
      lows = 0;
      for (int k = 0; k < 5; k++) begin
        if (k > 0) begin
          @(posedge clk);
          #1;
        end
        if (!req_ready) lows++;
        chk($sformatf("b2b rsp_valid k%0d", k), {31'd0, rsp_valid}, (k == 3) ? 32'd1 : 32'd0);
        if (k == 3) begin
          chk("b2b rdata1", rsp_rdata, 32'hDEADBEEF);
          chk("b2b ready_in_resp", {31'd0, req_ready}, 32'd0);
          chk("b2b stall_in_resp", {31'd0, stall}, 32'd0);
        end
      end
      chk("b2b ready_low_cycles", lows, 4);
    end
    @(posedge clk);
    #1;
    chk("b2b second_accept", {31'd0, req_ready}, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h83, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b rsp_valid2", {31'd0, rsp_valid}, 32'd1);
    chk("b2b rdata2", rsp_rdata, 32'h11AA3344);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);

    // Reset during WAIT discards a pending store to 0x20
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h20, 32'h55);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid rst ready", {31'd0, req_ready}, 32'd1);
    chk("mid rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid rst rdata", rsp_rdata, 32'd0);
    chk("mid rst err", {31'd0, rsp_err}, 32'd0);
    chk("mid rst stall", {31'd0, stall}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      vec_t v;
      v = '{1'b0, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 1'b1};
      txn(1'b0, v, "after_rst load");
      v = '{1'b1, 1'b0, 32'h10, 32'h0BADCAFE, 32'h0, 1'b0, 1'b0};
      txn(1'b1, v, "w0 store");
      v = '{1'b0, 1'b0, 32'h10, 32'h0, 32'h0BADCAFE, 1'b0, 1'b1};
      txn(1'b1, v, "w0 load");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
